fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 105 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Two-producer write arbiter in front of a single FIFO write port.
// Round-robin ownership with bounded bursts and a one-cycle arbitration gap.
module fifo_wr_arb #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              full,
    output logic              WREN,
    output logic [DATA_W-1:0] data_in,
    output logic [1:0]        grant,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

    state_t     state, state_nxt;
    logic       last, last_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 4'd0;
            wr_count  <= 16'd0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            if (xfer)
                wr_count <= wr_count + 16'd1;
        end
    end

    // Outputs decode from the registered state, so the async reset clears them at once.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        grant     = 2'b00;
        ack0      = 1'b0;
        ack1      = 1'b0;
        data_in   = '0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                burst_nxt = 4'd0;
                if (req0 && req1)
                    state_nxt = last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                grant   = 2'b01;
                data_in = data0;
                ack0    = req0 && !full;
                xfer    = ack0;
                if (!req0 || (xfer && burst_cnt == BURST_LAST)) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                    burst_nxt = 4'd0;
                end else if (xfer) begin
                    burst_nxt = burst_cnt + 4'd1;
                end
            end
            OWN1: begin
                grant   = 2'b10;
                data_in = data1;
                ack1    = req1 && !full;
                xfer    = ack1;
                if (!req1 || (xfer && burst_cnt == BURST_LAST)) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                    burst_nxt = 4'd0;
                end else if (xfer) begin
                    burst_nxt = burst_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = 4'd0;
            end
        endcase
    end

    assign WREN = xfer;

endmodule
